// File: rtl/axis_egress_stats.sv
// axis_egress_stats: skid-buffered AXIS egress slice with per-port packet/byte statistics.
// Define AXIS_EGRESS_STATS_LEN_CHECK_EN to build the tuser length-mismatch counter.
module axis_egress_stats #(
  parameter int AXIS_DATA_WIDTH  = 512,
  parameter int AXIS_TUSER_WIDTH = 256,
  parameter int CNT_WIDTH        = 32,
  parameter int NUM_PORTS        = 8
) (
  input  logic                          axis_aclk,
  input  logic                          axis_resetn,
  input  logic [AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic [2:0]                    stat_sel,
  input  logic                          stat_clear,
  output logic [CNT_WIDTH-1:0]          stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]          stat_byte_cnt,
  output logic [CNT_WIDTH-1:0]          stat_len_err_cnt,
  output logic                          in_pkt
);
  localparam int KW  = AXIS_DATA_WIDTH / 8;
  localparam int PW  = AXIS_DATA_WIDTH + KW + AXIS_TUSER_WIDTH + 1;
  localparam int PCW = $clog2(KW + 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  typedef enum logic {IDLE, IN_PKT} state_t;
  logic [PW-1:0] in_beat, main_q, main_d, skid_q, skid_d;
  logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d, rdy_q, rdy_d;
  logic hs, load, commit;
  assign in_beat = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = main_q;
  assign m_axis_tvalid = main_vld_q;
  assign s_axis_tready = rdy_q;
  assign hs = s_axis_tvalid & rdy_q;
  assign load = ~main_vld_q | m_axis_tready;
  assign commit = hs & s_axis_tlast;
  // ready is held low whenever the skid holds a beat, so hs never coincides with a full skid
  always_comb begin
    main_vld_d = load ? (skid_vld_q | hs) : 1'b1;
    main_d     = !load ? main_q : skid_vld_q ? skid_q : hs ? in_beat : main_q;
    skid_vld_d = !load & (skid_vld_q | hs);
    skid_d     = (!load & hs) ? in_beat : skid_q;
    rdy_d      = !skid_vld_d;
  end
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end
  state_t state_q, state_d;
  logic [16:0] acc_q, acc_d, acc_new;
  logic [17:0] acc_sum;
  logic [7:0] dst_q, dst_d, dst_cur;
  logic [PCW-1:0] keep_cnt;
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < KW; i++) keep_cnt = keep_cnt + PCW'(s_axis_tkeep[i]);
  end
  // acc value including the current beat, saturating at 17 bits
  assign acc_sum = (state_q == IDLE ? 18'd0 : {1'b0, acc_q}) + 18'(keep_cnt);
  assign acc_new = acc_sum[17] ? '1 : acc_sum[16:0];
  assign dst_cur = state_q == IDLE ? s_axis_tuser[31:24] : dst_q;
  assign in_pkt  = state_q == IN_PKT;
  always_comb begin
    state_d = hs ? (s_axis_tlast ? IDLE : IN_PKT) : state_q;
    acc_d   = hs ? acc_new : acc_q;
    dst_d   = (hs && state_q == IDLE) ? s_axis_tuser[31:24] : dst_q;
  end
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      dst_q   <= dst_d;
    end
  end
  logic [CNT_WIDTH-1:0] pkt_cnt_q [NUM_PORTS], pkt_cnt_d [NUM_PORTS];
  logic [CNT_WIDTH-1:0] byte_cnt_q [NUM_PORTS], byte_cnt_d [NUM_PORTS];
  logic [CNT_WIDTH:0] bsum;
  always_comb begin
    bsum = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bsum = {1'b0, byte_cnt_q[i]} + (CNT_WIDTH+1)'(acc_new);
      pkt_cnt_d[i]  = stat_clear ? '0 :
                      (commit && dst_cur[i] && !(&pkt_cnt_q[i])) ? pkt_cnt_q[i] + ONE : pkt_cnt_q[i];
      byte_cnt_d[i] = stat_clear ? '0 :
                      (commit && dst_cur[i]) ? (bsum[CNT_WIDTH] ? '1 : bsum[CNT_WIDTH-1:0]) : byte_cnt_q[i];
    end
  end
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i]  <= '0;
        byte_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        pkt_cnt_q[i]  <= pkt_cnt_d[i];
        byte_cnt_q[i] <= byte_cnt_d[i];
      end
    end
  end
`ifdef AXIS_EGRESS_STATS_LEN_CHECK_EN
  logic [15:0] len_q, len_d, len_cur;
  logic [CNT_WIDTH-1:0] err_q, err_d;
  assign len_cur = state_q == IDLE ? s_axis_tuser[15:0] : len_q;
  always_comb begin
    len_d = (hs && state_q == IDLE) ? s_axis_tuser[15:0] : len_q;
    err_d = stat_clear ? '0 :
            (commit && acc_new != {1'b0, len_cur} && !(&err_q)) ? err_q + ONE : err_q;
  end
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      len_q <= '0;
      err_q <= '0;
    end else begin
      len_q <= len_d;
      err_q <= err_d;
    end
  end
  assign stat_len_err_cnt = err_q;
`else
  assign stat_len_err_cnt = '0;
`endif
  logic [CNT_WIDTH-1:0] stat_pkt_q, stat_pkt_d, stat_byte_q, stat_byte_d;
  always_comb begin
    stat_pkt_d  = (int'(stat_sel) < NUM_PORTS) ? pkt_cnt_q[stat_sel] : '0;
    stat_byte_d = (int'(stat_sel) < NUM_PORTS) ? byte_cnt_q[stat_sel] : '0;
  end
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      stat_pkt_q  <= '0;
      stat_byte_q <= '0;
    end else begin
      stat_pkt_q  <= stat_pkt_d;
      stat_byte_q <= stat_byte_d;
    end
  end
  assign stat_pkt_cnt  = stat_pkt_q;
  assign stat_byte_cnt = stat_byte_q;
endmodule

// File: tb/tb_axis_egress_stats.sv
// tb_axis_egress_stats: randomized scoreboard and packet-level statistics model for axis_egress_stats.
module tb_axis_egress_stats;
  localparam longint MAXC = 64'hFFFF_FFFF;
  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic [255:0] user;
    logic         last;
  } beat_t;
  typedef struct {
    logic [7:0] dst;
    int         len;
    int         bytes;
  } pkt_t;
  logic axis_aclk = 0, axis_resetn = 0;
  logic [511:0] s_axis_tdata = '0, m_axis_tdata;
  logic [63:0] s_axis_tkeep = '0, m_axis_tkeep;
  logic [255:0] s_axis_tuser = '0, m_axis_tuser;
  logic s_axis_tvalid = 0, s_axis_tready, s_axis_tlast = 0;
  logic m_axis_tvalid, m_axis_tready = 0, m_axis_tlast;
  logic [2:0] stat_sel = '0;
  logic stat_clear = 0;
  logic [31:0] stat_pkt_cnt, stat_byte_cnt, stat_len_err_cnt;
  logic in_pkt;
  axis_egress_stats dut (
    .axis_aclk(axis_aclk), .axis_resetn(axis_resetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .stat_sel(stat_sel), .stat_clear(stat_clear), .stat_pkt_cnt(stat_pkt_cnt),
    .stat_byte_cnt(stat_byte_cnt), .stat_len_err_cnt(stat_len_err_cnt), .in_pkt(in_pkt)
  );
  always #5 axis_aclk = ~axis_aclk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  int n_chk = 0, n_fail = 0;
  beat_t in_q[$], exp_q[$];
  pkt_t pkt_q[$];
  longint mdl_pkt[8], mdl_byte[8], mdl_err;
  bit mdl_in_pkt, in_acc, clr_arm, clr_hit, burst;
  int tr_mode, popped;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void zero_model();
    for (int i = 0; i < 8; i++) begin
      mdl_pkt[i] = 0;
      mdl_byte[i] = 0;
    end
    mdl_err = 0;
  endfunction
  function automatic void commit(input pkt_t p);
    for (int i = 0; i < 8; i++)
      if (p.dst[i]) begin
        mdl_pkt[i] = (mdl_pkt[i] + 1 > MAXC) ? MAXC : mdl_pkt[i] + 1;
        mdl_byte[i] = (mdl_byte[i] + p.bytes > MAXC) ? MAXC : mdl_byte[i] + p.bytes;
      end
`ifdef AXIS_EGRESS_STATS_LEN_CHECK_EN
    if (p.bytes != p.len) mdl_err = (mdl_err + 1 > MAXC) ? MAXC : mdl_err + 1;
`endif
  endfunction
  task automatic add_pkt(input logic [7:0] dst, input int nb, input logic [63:0] lk, input int len);
    pkt_t p;
    beat_t b;
    p.dst = dst;
    p.bytes = 64 * (nb - 1) + $countones(lk);
    if (p.bytes > 131071) p.bytes = 131071;
    p.len = (len < 0) ? p.bytes : len;
    pkt_q.push_back(p);
    for (int k = 0; k < nb; k++) begin
      for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
      for (int w = 0; w < 8; w++) b.user[w*32 +: 32] = $urandom;
      if (k == 0) begin
        b.user[15:0] = p.len[15:0];
        b.user[31:24] = dst;
      end
      b.keep = (k == nb - 1) ? lk : '1;
      b.last = (k == nb - 1);
      in_q.push_back(b);
    end
  endtask
  task automatic cycle();
    beat_t b, e;
    pkt_t p;
    @(negedge axis_aclk);
    stat_clear = 0;
    if (in_acc) begin
      b = in_q.pop_front();
      exp_q.push_back(b);
      popped++;
      if (b.last) begin
        p = pkt_q.pop_front();
        if (!clr_hit) commit(p);
        mdl_in_pkt = 0;
      end else mdl_in_pkt = 1;
    end
    if (clr_hit) zero_model();
    clr_hit = 0;
    chk("in_pkt", in_pkt, mdl_in_pkt);
    chk("m_tvalid", m_axis_tvalid, exp_q.size() != 0);
    chk("s_tready", s_axis_tready, exp_q.size() <= 1);
    if (!(s_axis_tvalid && !in_acc)) s_axis_tvalid = in_q.size() > 0 && (burst || $urandom_range(3) != 0);
    if (in_q.size() > 0) begin
      b = in_q[0];
      s_axis_tdata = b.data;
      s_axis_tkeep = b.keep;
      s_axis_tuser = b.user;
      s_axis_tlast = b.last;
    end
    m_axis_tready = tr_mode == 2 ? 1'b1 : tr_mode == 1 ? ~m_axis_tready : 1'($urandom_range(1));
    #1;
    in_acc = s_axis_tvalid & s_axis_tready;
    if (clr_arm && in_acc && s_axis_tlast) begin
      stat_clear = 1;
      clr_hit = 1;
      clr_arm = 0;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      chk("out_beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        for (int k = 0; k < 8; k++) chk("tdata", m_axis_tdata[k*64 +: 64], e.data[k*64 +: 64]);
        for (int k = 0; k < 4; k++) chk("tuser", m_axis_tuser[k*64 +: 64], e.user[k*64 +: 64]);
        chk("tkeep", m_axis_tkeep, e.keep);
        chk("tlast", m_axis_tlast, e.last);
      end
    end
  endtask
  task automatic run(input int budget);
    for (int c = 0; c < budget && (in_q.size() != 0 || exp_q.size() != 0); c++) cycle();
    chk("drain_left", in_q.size() + exp_q.size(), 0);
  endtask
  task automatic check_stats();
    for (int p = 0; p < 8; p++) begin
      stat_sel = 3'(p);
      cycle();
      chk($sformatf("pkt_cnt[%0d]", p), stat_pkt_cnt, mdl_pkt[p]);
      chk($sformatf("byte_cnt[%0d]", p), stat_byte_cnt, mdl_byte[p]);
    end
    chk("len_err_cnt", stat_len_err_cnt, mdl_err);
  endtask
  task automatic do_reset();
    axis_resetn = 0;
    s_axis_tvalid = 0;
    #1;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_in_pkt", in_pkt, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tdata", m_axis_tdata[63:0], 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    in_q.delete();
    exp_q.delete();
    pkt_q.delete();
    in_acc = 0;
    clr_hit = 0;
    clr_arm = 0;
    mdl_in_pkt = 0;
    zero_model();
    repeat (2) @(negedge axis_aclk);
    axis_resetn = 1;
  endtask
  initial begin
    zero_model();
    burst = 0;
    tr_mode = 2;
    do_reset();
    add_pkt(8'h01, 1, '1, -1);
    run(50);
    check_stats();
    add_pkt(8'h05, 3, 64'hFFFF, -1);
    run(50);
    check_stats();
    stat_clear = 1;
    clr_hit = 1;
    cycle();
    burst = 1;
    tr_mode = 1;
    for (int i = 0; i < 100; i++) add_pkt(8'h01, 1, '1, -1);
    run(1000);
    check_stats();
    tr_mode = 0;
    burst = 0;
    add_pkt(8'h02, 1, '1, 100);
    run(50);
    check_stats();
    clr_arm = 1;
    add_pkt(8'h03, 2, 64'hFF, 7);
    run(50);
    check_stats();
    add_pkt(8'h80, 2, 64'h0F, -1);
    run(50);
    check_stats();
    burst = 1;
    tr_mode = 2;
    popped = 0;
    add_pkt(8'h01, 4, '1, -1);
    for (int c = 0; c < 50 && popped < 2; c++) cycle();
    chk("mid_beats", popped, 2);
    do_reset();
    add_pkt(8'h01, 1, 64'h3FF, -1);
    run(50);
    check_stats();
    for (int r = 0; r < 4; r++) begin
      burst = r[0];
      tr_mode = 0;
      for (int i = 0; i < 10; i++)
        add_pkt(($urandom_range(5) == 0) ? 8'h00 : 8'($urandom_range(255)), $urandom_range(1, 5),
                64'hFFFF_FFFF_FFFF_FFFF >> $urandom_range(63),
                ($urandom_range(4) == 0) ? $urandom_range(65535) : -1);
      run(2000);
      check_stats();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
